draw_cmd_scheduler: RTL and testbench

Command scheduler for the drawing pipeline. It queues drawing opcodes from the command interface and starts exactly one drawing engine at a time: circle fill/draw, rectangle fill/draw, line draw, or a frame update. It drives the shared 4-bit `SEL` code that steers the coordinate output muxes to the active engine, and it returns `SEL` to IDLE whenever no command is in flight. It also supervises each engine with a watchdog and reports illegal opcodes and timeouts through a sticky error flag.

---
 rtl/draw_cmd_scheduler.sv | 147 ++++++++++++++
 tb/tb_draw_cmd_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_cmd_scheduler.sv
// Drawing command scheduler: queues opcodes, starts one engine at a time.
// Ports: CLK/RST_N, CMD_VALID/CMD_OP/CMD_READY in, ENG_START/ENG_DONE,
// FU_REQ/FU_ACK, SEL mux code, BUSY, sticky ERR with ERR_CLR.
module draw_cmd_scheduler #(
   parameter int DEPTH  = 4,
   parameter int WDOG_W = 20
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       CMD_VALID,
   input  logic [3:0] CMD_OP,
   output logic       CMD_READY,
   output logic [4:0] ENG_START,
   input  logic [4:0] ENG_DONE,
   output logic       FU_REQ,
   input  logic       FU_ACK,
   output logic [3:0] SEL,
   output logic       BUSY,
   output logic       ERR,
   input  logic       ERR_CLR
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   // Last count before the limit: reaching all-ones without done times out.
   localparam logic [WDOG_W-1:0] WLAST = {{(WDOG_W-1){1'b1}}, 1'b0};
   localparam logic [3:0] OP_FU   = 4'd10;
   localparam logic [3:0] OP_IDLE = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FU_WAIT
   } state_t;

   logic [3:0]        mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [AW:0]       count;
   state_t            state;
   logic [3:0]        cur_op;
   logic [WDOG_W-1:0] wdog;
   logic              err;

   logic       accept;
   logic       queue_op;
   logic       noop;
   logic       push;
   logic       pop;
   logic       illegal;
   logic [4:0] op_oh;
   logic       waiting;
   logic       done;
   logic       timeout;

   assign CMD_READY = (count < FULL);
   assign accept    = CMD_VALID && CMD_READY;
   assign queue_op  = (CMD_OP <= 4'd4) || (CMD_OP == OP_FU);
   assign noop      = (CMD_OP == OP_IDLE);
   assign push      = accept && queue_op;
   assign illegal   = accept && !queue_op && !noop;
   assign pop       = (state == S_IDLE) && (count != '0);

   assign op_oh   = (cur_op <= 4'd4) ? (5'b00001 << cur_op) : 5'b00000;
   assign waiting = (state == S_WAIT) || (state == S_FU_WAIT);
   assign done    = ((state == S_WAIT) && |(ENG_DONE & op_oh)) ||
                    ((state == S_FU_WAIT) && FU_ACK);
   // Completion on the limit cycle wins over the timeout.
   assign timeout = waiting && !done && (wdog == WLAST);

   always_ff @(posedge CLK) begin
      if (push) mem[wptr] <= CMD_OP;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= S_IDLE;
         cur_op <= OP_IDLE;
         wdog   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pop) begin
                  cur_op <= mem[rptr];
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wdog <= '0;
               if (cur_op == OP_FU)       state <= S_FU_WAIT;
               else if (cur_op <= 4'd4)   state <= S_WAIT;
               else                       state <= S_IDLE;
            end
            S_WAIT, S_FU_WAIT: begin
               if (done || timeout) state <= S_IDLE;
               else                 wdog  <= wdog + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Set beats a simultaneous clear.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) err <= 1'b0;
      else        err <= (err && !ERR_CLR) || illegal || timeout;
   end

   always_comb begin
      SEL       = OP_IDLE;
      ENG_START = 5'b00000;
      FU_REQ    = 1'b0;
      unique case (state)
         S_ISSUE: begin
            SEL       = cur_op;
            ENG_START = op_oh;
            FU_REQ    = (cur_op == OP_FU);
         end
         S_WAIT: SEL = cur_op;
         S_FU_WAIT: begin
            SEL    = OP_FU;
            FU_REQ = 1'b1;
         end
         default: ;
      endcase
   end

   assign BUSY = (state != S_IDLE) || (count != '0);
   assign ERR  = err;

endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Testbench for draw_cmd_scheduler: directed stimulus, issue scoreboard.
// Expected issue order is queued on push; a monitor checks each start.
module tb_draw_cmd_scheduler;
   logic       CLK = 1'b0;
   logic       RST_N;
   logic       CMD_VALID;
   logic [3:0] CMD_OP;
   logic       CMD_READY;
   logic [4:0] ENG_START;
   logic [4:0] ENG_DONE;
   logic       FU_REQ;
   logic       FU_ACK;
   logic [3:0] SEL;
   logic       BUSY;
   logic       ERR;
   logic       ERR_CLR;

   int n_chk  = 0;
   int n_fail = 0;
   logic [3:0] sb [$];
   logic fu_prev = 1'b0;

   always #5 CLK = ~CLK;

   draw_cmd_scheduler #(.DEPTH(4), .WDOG_W(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP),
      .CMD_READY(CMD_READY), .ENG_START(ENG_START), .ENG_DONE(ENG_DONE),
      .FU_REQ(FU_REQ), .FU_ACK(FU_ACK), .SEL(SEL), .BUSY(BUSY),
      .ERR(ERR), .ERR_CLR(ERR_CLR)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   // Monitor: every start pulse / FU_REQ rise must match the scoreboard head.
   always @(negedge CLK) begin
      logic [3:0] e;
      logic [4:0] oh;
      if (RST_N === 1'b1 && (ENG_START != 5'b0 || (FU_REQ && !fu_prev))) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_issue: got sel %0h start %b", SEL, ENG_START);
         end else begin
            e = sb.pop_front();
            chk("issue_sel", {28'b0, SEL}, {28'b0, e});
            if (e == 4'd10) begin
               chk("issue_fu", {26'b0, ENG_START, FU_REQ}, 32'h1);
            end else begin
               oh = 5'b00001 << e;
               chk("issue_start", {26'b0, ENG_START, FU_REQ}, {26'b0, oh, 1'b0});
            end
         end
      end
      fu_prev = FU_REQ;
   end

   task automatic push(input logic [3:0] op);
      int w;
      CMD_VALID = 1'b1;
      CMD_OP    = op;
      for (w = 0; w < 40; w++) begin
         @(negedge CLK);
         if (CMD_READY) break;
      end
      if (w == 40) bound_fail("push_ready");
      @(posedge CLK);
      #1;
      CMD_VALID = 1'b0;
      if (op <= 4'd4 || op == 4'd10) sb.push_back(op);
   endtask

   task automatic wait_sel(input logic [3:0] op);
      int i;
      for (i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (SEL == op) break;
      end
      if (i == 40) bound_fail("wait_sel");
   endtask

   task automatic idle_chk(input string nm);
      chk({nm, "_sel"},   {28'b0, SEL}, 32'hF);
      chk({nm, "_start"}, {27'b0, ENG_START}, 32'h0);
      chk({nm, "_fu"},    {31'b0, FU_REQ}, 32'h0);
      chk({nm, "_ready"}, {31'b0, CMD_READY}, 32'h1);
      chk({nm, "_busy"},  {31'b0, BUSY}, 32'h0);
      chk({nm, "_err"},   {31'b0, ERR}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation bound expired");
      $fatal(1);
   end

   initial begin
      // Reset with random inputs
      RST_N = 1'b0;
      for (int i = 0; i < 6; i++) begin
         CMD_VALID = 1'($urandom);
         CMD_OP    = 4'($urandom);
         ENG_DONE  = 5'($urandom);
         FU_ACK    = 1'($urandom);
         ERR_CLR   = 1'($urandom);
         @(negedge CLK);
         idle_chk("rst");
      end
      CMD_VALID = 1'b0; CMD_OP = 4'd0; ENG_DONE = 5'b0;
      FU_ACK = 1'b0; ERR_CLR = 1'b0;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      // Single RF
      push(4'd2);
      @(negedge CLK);
      chk("rf_e0_sel", {28'b0, SEL}, 32'hF);
      chk("rf_e0_busy", {31'b0, BUSY}, 32'h1);
      @(negedge CLK);
      chk("rf_issue_start", {27'b0, ENG_START}, 32'h4);
      chk("rf_issue_sel", {28'b0, SEL}, 32'h2);
      @(negedge CLK);
      chk("rf_wait_start", {27'b0, ENG_START}, 32'h0);
      chk("rf_wait_sel", {28'b0, SEL}, 32'h2);
      @(posedge CLK); #1;
      ENG_DONE = 5'b01001;
      @(posedge CLK); #1;
      ENG_DONE = 5'b00101;
      @(negedge CLK);
      chk("rf_other_done", {28'b0, SEL}, 32'h2);
      @(posedge CLK); #1;
      ENG_DONE = 5'b0;
      @(negedge CLK);
      chk("rf_done_sel", {28'b0, SEL}, 32'hF);
      chk("rf_done_busy", {31'b0, BUSY}, 32'h0);

      // Queue full and ordering
      @(posedge CLK); #1;
      for (int i = 0; i < 5; i++) push(4'(i));
      CMD_VALID = 1'b1;
      CMD_OP    = 4'd0;
      @(negedge CLK);
      chk("q_full_ready", {31'b0, CMD_READY}, 32'h0);
      CMD_VALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_sel(4'(i));
         @(posedge CLK); #1;
         ENG_DONE = 5'(1 << i);
         @(posedge CLK); #1;
         ENG_DONE = 5'b0;
         @(negedge CLK);
         chk("q_sel_gap", {28'b0, SEL}, 32'hF);
      end
      chk("q_busy_end", {31'b0, BUSY}, 32'h0);

      // Frame update, ack 7 cycles after FU_REQ rises
      @(posedge CLK); #1;
      push(4'd10);
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         if (k == 0) begin
            chk("fu_pre_req", {31'b0, FU_REQ}, 32'h0);
         end else begin
            chk("fu_req_held", {31'b0, FU_REQ}, 32'h1);
            chk("fu_sel_held", {28'b0, SEL}, 32'hA);
         end
         if (k == 7) FU_ACK = 1'b1;
      end
      @(posedge CLK); #1;
      FU_ACK = 1'b0;
      @(negedge CLK);
      chk("fu_req_drop", {31'b0, FU_REQ}, 32'h0);
      chk("fu_sel_drop", {28'b0, SEL}, 32'hF);

      // Illegal and no-op opcodes
      @(posedge CLK); #1;
      push(4'd7);
      @(negedge CLK);
      chk("ill_err", {31'b0, ERR}, 32'h1);
      chk("ill_busy", {31'b0, BUSY}, 32'h0);
      @(posedge CLK); #1;
      ERR_CLR = 1'b1;
      @(posedge CLK); #1;
      ERR_CLR = 1'b0;
      @(negedge CLK);
      chk("clr_err", {31'b0, ERR}, 32'h0);
      @(posedge CLK); #1;
      push(4'd15);
      repeat (3) @(negedge CLK);
      chk("noop_err", {31'b0, ERR}, 32'h0);
      chk("noop_busy", {31'b0, BUSY}, 32'h0);
      @(posedge CLK); #1;
      ERR_CLR = 1'b1;
      push(4'd7);
      ERR_CLR = 1'b0;
      @(negedge CLK);
      chk("set_wins_err", {31'b0, ERR}, 32'h1);
      @(posedge CLK); #1;
      push(4'd15);
      @(negedge CLK);
      chk("noop_keep_err", {31'b0, ERR}, 32'h1);
      @(posedge CLK); #1;
      ERR_CLR = 1'b1;
      @(posedge CLK); #1;
      ERR_CLR = 1'b0;
      @(negedge CLK);
      chk("clr2_err", {31'b0, ERR}, 32'h0);

      // Watchdog timeout on LD
      @(posedge CLK); #1;
      push(4'd4);
      for (int k = 0; k < 18; k++) begin
         @(negedge CLK);
         if (k == 16) begin
            chk("wd_pre_sel", {28'b0, SEL}, 32'h4);
            chk("wd_pre_err", {31'b0, ERR}, 32'h0);
         end
         if (k == 17) begin
            chk("wd_to_sel", {28'b0, SEL}, 32'hF);
            chk("wd_to_err", {31'b0, ERR}, 32'h1);
         end
      end
      @(posedge CLK); #1;
      ENG_DONE = 5'b10000;
      @(posedge CLK); #1;
      ENG_DONE = 5'b0;
      @(negedge CLK);
      chk("wd_late_sel", {28'b0, SEL}, 32'hF);
      chk("wd_late_busy", {31'b0, BUSY}, 32'h0);
      @(posedge CLK); #1;
      ERR_CLR = 1'b1;
      @(posedge CLK); #1;
      ERR_CLR = 1'b0;

      // Watchdog: done exactly on the limit cycle
      push(4'd4);
      for (int k = 0; k < 17; k++) begin
         @(negedge CLK);
         if (k == 16) begin
            chk("wdl_pre_sel", {28'b0, SEL}, 32'h4);
            ENG_DONE = 5'b10000;
         end
      end
      @(posedge CLK); #1;
      ENG_DONE = 5'b0;
      @(negedge CLK);
      chk("wdl_sel", {28'b0, SEL}, 32'hF);
      chk("wdl_err", {31'b0, ERR}, 32'h0);

      // Reset mid-command with queued work and ERR set
      @(posedge CLK); #1;
      push(4'd7);
      push(4'd2);
      push(4'd0);
      push(4'd1);
      RST_N = 1'b0;
      sb.delete();
      @(negedge CLK);
      idle_chk("rst_mid");
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      ENG_DONE = 5'b00100;
      @(posedge CLK); #1;
      ENG_DONE = 5'b0;
      repeat (3) @(negedge CLK);
      idle_chk("rst_after");

      chk("sb_empty", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
